// File: rtl/store_trace_fifo.sv
// store_trace_fifo: snoops the core's data-memory write port. In CAPTURE it queues
// each in-range store as {address, data, byte flag} in a DEPTH-entry FIFO and
// presents the entries on a valid/ready stream. A store to STOP_ADDR ends capture.
// Capture then drains to DONE.
// Optional build macro STORE_TRACE_MATCH_EN adds a sticky 'match' flag for one
// expected store (MATCH_ADDR / MATCH_DATA). Without the macro, match is tied to 0.
module store_trace_fifo #(
    parameter int          DEPTH      = 16,
    parameter logic [31:0] ADDR_LO    = 32'd0,
    parameter logic [31:0] ADDR_HI    = 32'd255,
    parameter logic [31:0] STOP_ADDR  = 32'd252,
    parameter logic [31:0] MATCH_ADDR = 32'd200,
    parameter logic [31:0] MATCH_DATA = 32'd5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     MemWrite,
    input  logic                     ByteMem,
    input  logic [31:0]              DataAdr,
    input  logic [31:0]              WriteData,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic                     out_byte,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic                     done,
    output logic                     match
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [31:0]     r_mem_addr [DEPTH];
    logic [31:0]     r_mem_data [DEPTH];
    logic            r_mem_byte [DEPTH];

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   w_rd_ptr_nxt1;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;

    logic            r_valid;
    logic [31:0]     r_out_addr;
    logic [31:0]     r_out_data;
    logic            r_out_byte;
    logic [31:0]     w_head_addr;
    logic [31:0]     w_head_data;
    logic            w_head_byte;

    logic            r_overflow;
    logic [7:0]      r_drop_count;
    logic            r_done;

    logic [32:0]     w_lo_diff;
    logic [32:0]     w_hi_diff;
    logic            w_in_range;
    logic            w_qual;
    logic            w_is_stop;
    logic [31:0]     w_entry_data;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    // Range check done as 33-bit subtractions so a zero lower bound stays a real compare.
    assign w_lo_diff     = {1'b0, DataAdr} - {1'b0, ADDR_LO};
    assign w_hi_diff     = {1'b0, ADDR_HI} - {1'b0, DataAdr};
    assign w_in_range    = ~w_lo_diff[32] & ~w_hi_diff[32];
    assign w_qual        = (r_state == S_CAPTURE) & MemWrite & w_in_range;
    assign w_is_stop     = (DataAdr == STOP_ADDR);
    assign w_entry_data  = ByteMem ? {24'd0, WriteData[7:0]} : WriteData;

    // A full FIFO still accepts a store when the head leaves on the same edge.
    assign w_pop         = (r_count != CNT_ZERO) & out_ready;
    assign w_push        = w_qual & ((r_count != CNT_FULL) | w_pop);
    assign w_drop        = w_qual & ~w_push;
    assign w_rd_ptr_nxt1 = r_rd_ptr + PTR_ONE;

    // Occupancy after this edge.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_ONE;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Head entry after this edge; an empty FIFO keeps showing the last head.
    always_comb begin
        w_head_addr = r_out_addr;
        w_head_data = r_out_data;
        w_head_byte = r_out_byte;
        if (w_pop && (r_count != CNT_ONE)) begin
            w_head_addr = r_mem_addr[w_rd_ptr_nxt1];
            w_head_data = r_mem_data[w_rd_ptr_nxt1];
            w_head_byte = r_mem_byte[w_rd_ptr_nxt1];
        end else if (w_push && (w_pop || (r_count == CNT_ZERO))) begin
            w_head_addr = DataAdr;
            w_head_data = w_entry_data;
            w_head_byte = ByteMem;
        end else begin
            w_head_addr = r_out_addr;
            w_head_data = r_out_data;
            w_head_byte = r_out_byte;
        end
    end

    // Capture-control next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_CAPTURE;
                else       w_state_nxt = S_IDLE;
            end
            S_CAPTURE: begin
                if (w_qual && w_is_stop) w_state_nxt = S_DRAIN;
                else                     w_state_nxt = S_CAPTURE;
            end
            S_DRAIN: begin
                if (w_count_nxt == CNT_ZERO) w_state_nxt = S_DONE;
                else                         w_state_nxt = S_DRAIN;
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage; slot contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= DataAdr;
            r_mem_data[r_wr_ptr] <= w_entry_data;
            r_mem_byte[r_wr_ptr] <= ByteMem;
        end
    end

    // State, pointers, occupancy, registered stream outputs and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= CNT_ZERO;
            r_valid      <= 1'b0;
            r_out_addr   <= 32'd0;
            r_out_data   <= 32'd0;
            r_out_byte   <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
            r_done       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_valid    <= (w_count_nxt != CNT_ZERO);
            r_out_addr <= w_head_addr;
            r_out_data <= w_head_data;
            r_out_byte <= w_head_byte;
            r_done     <= (w_state_nxt == S_DONE);
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'd255) r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

`ifdef STORE_TRACE_MATCH_EN
    logic r_match;

    // Sticky flag for the expected store, counted whether or not the FIFO had room.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_match <= 1'b0;
        end else if (w_qual && (DataAdr == MATCH_ADDR) && (w_entry_data == MATCH_DATA)) begin
            r_match <= 1'b1;
        end
    end

    assign match = r_match;
`else
    logic w_unused_match_cfg;
    assign w_unused_match_cfg = ^{MATCH_ADDR, MATCH_DATA};
    assign match = 1'b0;
`endif

    assign out_valid  = r_valid;
    assign out_addr   = r_out_addr;
    assign out_data   = r_out_data;
    assign out_byte   = r_out_byte;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
    assign done       = r_done;

endmodule

// File: tb/tb_store_trace_fifo.sv
// Directed bench for store_trace_fifo with a scoreboard queue of expected entries.
module tb_store_trace_fifo;

    logic        clk;
    logic        reset;
    logic        start;
    logic        MemWrite;
    logic        ByteMem;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        out_byte;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        done;
    logic        match;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        b;
    } ent_t;

    ent_t        sb[$];
    bit          m_cap;
    logic        m_ovf;
    logic [7:0]  m_drop;
    int          n_pass;
    int          n_total;

    store_trace_fifo dut (
        .clk(clk), .reset(reset), .start(start), .MemWrite(MemWrite),
        .ByteMem(ByteMem), .DataAdr(DataAdr), .WriteData(WriteData),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_byte(out_byte), .count(count),
        .overflow(overflow), .drop_count(drop_count), .done(done), .match(match)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head();
        chk("head_valid", {31'd0, out_valid}, 32'd1);
        if (sb.size() != 0) begin
            chk("head_addr", out_addr, sb[0].a);
            chk("head_data", out_data, sb[0].d);
            chk("head_byte", {31'd0, out_byte}, {31'd0, sb[0].b});
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_cap  = 1'b0;
        m_ovf  = 1'b0;
        m_drop = 8'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_cap = 1'b1;
    endtask

    // One store cycle, optionally popping the head on the same edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic b, input bit pop);
        ent_t e;
        if (pop && sb.size() != 0) begin
            check_head();
            out_ready = 1'b1;
            void'(sb.pop_front());
        end
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        ByteMem   = b;
        if (m_cap && (a <= 32'd255)) begin
            e.a = a;
            e.d = b ? {24'd0, d[7:0]} : d;
            e.b = b;
            if (sb.size() < 16) begin
                sb.push_back(e);
            end else begin
                m_ovf = 1'b1;
                if (m_drop != 8'd255) m_drop++;
            end
            if (a == 32'd252) m_cap = 1'b0;
        end
        tick();
        MemWrite  = 1'b0;
        out_ready = 1'b0;
        chk("count_after_store", {27'd0, count}, sb.size());
    endtask

    task automatic drain_one();
        check_head();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
        chk("count_after_pop", {27'd0, count}, sb.size());
    endtask

    task automatic drain_all();
        for (int k = 0; k < 40 && sb.size() != 0; k++) drain_one();
        chk("drained_empty", {27'd0, count}, 32'd0);
        chk("drained_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b1; start = 1'b0; MemWrite = 1'b0; ByteMem = 1'b0;
        DataAdr = 32'd0; WriteData = 32'd0; out_ready = 1'b0;
        model_reset();
        tick();
        tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_addr", out_addr, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_byte", {31'd0, out_byte}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_drop", {24'd0, drop_count}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_match", {31'd0, match}, 32'd0);
        reset = 1'b0;

        // Not armed: nothing captured.
        store(32'h10, 32'h11, 1'b0, 1'b0);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);

        // Arm, then a word store.
        arm();
        store(32'h10, 32'h11, 1'b0, 1'b0);
        chk("word_addr", out_addr, 32'h10);
        chk("word_data", out_data, 32'h11);
        drain_one();

        // Byte store keeps only the low byte.
        store(32'h20, 32'hDEADBEEF, 1'b1, 1'b0);
        chk("byte_data", out_data, 32'h000000EF);
        chk("byte_flag", {31'd0, out_byte}, 32'd1);
        drain_one();

        // Out of range address.
        store(32'h300, 32'h1, 1'b0, 1'b0);
        chk("oor_valid", {31'd0, out_valid}, 32'd0);

        // Overflow: 18 stores into a 16-deep FIFO.
        for (int i = 1; i <= 18; i++) store(32'(4 * i), 32'(i), 1'b0, 1'b0);
        chk("full_count", {27'd0, count}, 32'd16);
        chk("ovf_flag", {31'd0, overflow}, {31'd0, m_ovf});
        chk("drop_cnt", {24'd0, drop_count}, {24'd0, m_drop});
        chk("drop_two", {24'd0, drop_count}, 32'd2);
        drain_all();

        // Refill, then push and pop together while full.
        for (int i = 0; i < 16; i++) store(32'h80 + 32'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
        store(32'hC0, 32'h99, 1'b0, 1'b1);
        chk("full_pushpop_count", {27'd0, count}, 32'd16);
        chk("full_pushpop_drop", {24'd0, drop_count}, 32'd2);
        drain_all();

        // Stop address ends capture, drain leads to done.
        store(32'h50, 32'h7, 1'b0, 1'b0);
        store(32'd252, 32'hABC, 1'b0, 1'b0);
        chk("stop_count", {27'd0, count}, 32'd2);
        store(32'h54, 32'h8, 1'b0, 1'b0);
        chk("done_early", {31'd0, done}, 32'd0);
        drain_one();
        chk("stop_last_addr", out_addr, 32'd252);
        drain_one();
        chk("done_set", {31'd0, done}, 32'd1);
        store(32'h10, 32'h33, 1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        store(32'h10, 32'h34, 1'b0, 1'b0);
        chk("done_hold", {31'd0, done}, 32'd1);

        // Asynchronous reset mid-stream at count 5 with overflow set.
        do_reset();
        arm();
        for (int i = 1; i <= 18; i++) store(32'(i), 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) drain_one();
        chk("mid_count", {27'd0, count}, 32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", {27'd0, count}, 32'd0);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ovf", {31'd0, overflow}, 32'd0);
        chk("arst_drop", {24'd0, drop_count}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        tick();
        reset = 1'b0;
        model_reset();

        // Match flag.
        arm();
        store(32'd200, 32'd6, 1'b0, 1'b0);
        chk("match_wrong_data", {31'd0, match}, 32'd0);
        store(32'd200, 32'd5, 1'b0, 1'b0);
`ifdef STORE_TRACE_MATCH_EN
        chk("match_set", {31'd0, match}, 32'd1);
        store(32'd200, 32'd6, 1'b0, 1'b0);
        chk("match_sticky", {31'd0, match}, 32'd1);
`else
        chk("match_off", {31'd0, match}, 32'd0);
        store(32'd200, 32'd6, 1'b0, 1'b0);
        chk("match_off_hold", {31'd0, match}, 32'd0);
`endif
        drain_all();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
